pixel_writer: RTL and testbench
===============================

# pixel_writer

Framebuffer-side consumer of the pixel stream produced by the line drawer. Accepts (x, y, color) pixels over the rts/rtr handshake, buffers them in a small FIFO, computes the linear framebuffer address, and issues single-word writes to video memory under a req/ack handshake. Sits between the line drawer output and the framebuffer RAM port.

## Interface
- H_RES, 640, pixels per line; address multiplier.
- V_RES, 480, lines per frame; clip bound.
- ADDR_W, 19, framebuffer address width.
- COLOR_W, 12, pixel color width.
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2).

- clk  in  1  system clock, all state on rising edge.
- rst_  in  1  asynchronous, active-high reset (rst_ = 1 resets).
- x_in  in  10  pixel column.
- y_in  in  10  pixel row.
- color_in  in  COLOR_W  pixel color.
- in_rts  in  1  upstream has a valid pixel.
- in_rtr  out  1  block can accept a pixel (FIFO not full).
- mem_addr  out  ADDR_W  write address, y*H_RES + x.
- mem_data  out  COLOR_W  write data.
- mem_we  out  1  write request; held until mem_ack.
- mem_ack  in  1  memory accepted the write this cycle.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- pix_count  out  20  completed writes, wraps at 2^20.
- drop_count  out  16  pixels discarded by clipping, wraps at 2^16.

## Operation
- Transfer occurs on a rising edge with in_rts && in_rtr; pixel pushed into FIFO.
- in_rtr = !full, independent of in_rts and of a same-cycle pop; a full FIFO never accepts, even while popping.
- FSM states IDLE, CALC, WRITE:
  - IDLE: if FIFO non-empty, pop head into pixel register → CALC; else stay.
  - CALC: register mem_addr = y*H_RES + x (truncated to ADDR_W) and mem_data = color. With clipping compiled in and x ≥ H_RES or y ≥ V_RES: increment drop_count, → IDLE, no write. Otherwise → WRITE.
  - WRITE: mem_we = 1; mem_addr/mem_data stable. On edge with mem_ack = 1: increment pix_count, → IDLE. mem_ack ignored outside WRITE.
- Pixels written strictly in arrival order; no coalescing.
- Counters wrap silently.

## Timing
- Reset values: in_rtr 0 during reset, 1 first cycle after; mem_we 0, mem_addr 0, mem_data 0, busy 0, pix_count 0, drop_count 0; FSM IDLE; FIFO empty.
- Reset mid-WRITE: mem_we deasserts asynchronously; in-flight and buffered pixels lost; no counter update.
- Latency: pixel accepted at edge 0 into empty FIFO with FSM IDLE → popped edge 1 → mem_we high after edge 2.
- Throughput with mem_ack tied 1: one write per 3 cycles; mem_we high 1 cycle each.
- mem_ack stalls: FSM holds WRITE indefinitely; FIFO fills, in_rtr drops after FIFO_DEPTH pending pixels.
- busy asserted from the edge after first accept until the edge the last write completes (or last drop).

## Configuration
- PIXEL_WRITER_CLIP_EN defined: CALC bounds check as above; out-of-range pixels dropped and counted.
- Undefined: no bounds check; every pixel written at truncated address y*H_RES + x; drop_count constant 0.

## Test plan
- Reset then single pixel (x=4, y=0, color=12'hF00), mem_ack=1 → mem_we high after edge 2, mem_addr=4, mem_data=12'hF00, pix_count=1, busy low afterwards.
- Pixel (x=639, y=479) → mem_addr=307199; pixel (x=0, y=10) → mem_addr=6400.
- mem_ack=0, push 6 pixels with in_rts held → 5 accepted (FIFO 4 + pixel register), in_rtr low; release mem_ack → all 5 written in order, then 6th accepted.
- CLIP_EN defined, pixel (x=640, y=0) then (x=1, y=1) → drop_count=1, single write mem_addr=641; undefined → two writes, addr 640 and 641.
- Assert rst_ while mem_we high and FIFO holds 3 → mem_we falls same cycle, counters 0, in_rtr 1 after release, no further writes.
- Line drawer stream (4,0)→(0,10) fed with mem_ack random 50% → pix_count equals pixels emitted, write order matches emission order.

Source files
------------

// File: rtl/pixel_writer_if.sv
// pixel_writer_if -- bundles the pixel stream input (rts/rtr), the framebuffer
// write port (req/ack) and the status outputs of pixel_writer.
// The writer itself connects through the slave modport; the environment that
// feeds pixels and answers memory writes uses the master modport.
interface pixel_writer_if #(
   parameter int ADDR_W  = 19,
   parameter int COLOR_W = 12
);
   // Pixel stream from the line drawer
   logic [9:0]         x_in;
   logic [9:0]         y_in;
   logic [COLOR_W-1:0] color_in;
   logic               in_rts;
   logic               in_rtr;
   // Framebuffer write port
   logic [ADDR_W-1:0]  mem_addr;
   logic [COLOR_W-1:0] mem_data;
   logic               mem_we;
   logic               mem_ack;
   // Status
   logic               busy;
   logic [19:0]        pix_count;
   logic [15:0]        drop_count;

   // Writer side
   modport slave (
      input  x_in, y_in, color_in, in_rts, mem_ack,
      output in_rtr, mem_addr, mem_data, mem_we, busy, pix_count, drop_count
   );

   // Environment side: pixel source, memory responder and status observer
   modport master (
      output x_in, y_in, color_in, in_rts, mem_ack,
      input  in_rtr, mem_addr, mem_data, mem_we, busy, pix_count, drop_count
   );
endinterface

// File: rtl/pixel_writer.sv
// pixel_writer -- framebuffer-side consumer of the line drawer pixel stream.
// Pixels (x, y, color) are buffered in a small FIFO, converted to the linear
// address y*H_RES + x and written one word at a time under a req/ack
// handshake (mem_we held until mem_ack).
//
// Build option: define PIXEL_WRITER_CLIP_EN to drop (and count) pixels with
// x >= H_RES or y >= V_RES. Without it every pixel is written at the
// truncated linear address and drop_count stays 0.
module pixel_writer #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int ADDR_W     = 19,
   parameter int COLOR_W    = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_,
   pixel_writer_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [9:0]         x;
      logic [9:0]         y;
      logic [COLOR_W-1:0] color;
   } pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WRITE = 2'd2
   } state_t;

   // Elaboration-time parameter sanity checks
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pixel_writer: FIFO_DEPTH must be a power of two >= 2");
   end
   if (H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 1024) begin : g_bad_res
      $error("pixel_writer: H_RES and V_RES must lie in 1..1024");
   end

   // ---------------------------------------------------------------------
   // Input FIFO
   // ---------------------------------------------------------------------
   pixel_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q,  count_d;
   logic               full, empty, push, pop;
   pixel_t             pixel_in;

   state_t             state_q, state_d;

   assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
   assign empty = (count_q == '0);

   // Ready depends only on fullness (and reset), never on a same-cycle pop.
   assign bus.in_rtr = !rst_ && !full;
   assign push       = bus.in_rts && bus.in_rtr;
   assign pop        = (state_q == IDLE) && !empty;

   assign pixel_in = '{x: bus.x_in, y: bus.y_in, color: bus.color_in};

   // FIFO pointer and occupancy next-state
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
   end

   // FIFO pointer and occupancy registers
   always_ff @(posedge clk or posedge rst_) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge value of every other, independent of block order.
      if (rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; the pointers alone define which
      // entries are valid, so clearing the data would only cost logic.
      if (push) begin
         fifo_mem[wr_ptr_q] <= pixel_in;
      end
   end

   // ---------------------------------------------------------------------
   // Write FSM
   // ---------------------------------------------------------------------
   pixel_t              pix_q,        pix_d;
   logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
   logic [COLOR_W-1:0]  mem_data_q,   mem_data_d;
   logic                mem_we_q,     mem_we_d;
   logic [19:0]         pix_count_q,  pix_count_d;
   logic [15:0]         drop_count_q, drop_count_d;

`ifdef PIXEL_WRITER_CLIP_EN
   logic out_of_range;
   assign out_of_range = ({1'b0, pix_q.x} >= 11'(H_RES)) ||
                         ({1'b0, pix_q.y} >= 11'(V_RES));
`endif

   // FSM next-state: pop a pixel, compute its address, then hold the write
   always_comb begin
      state_d      = state_q;
      pix_d        = pix_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_we_d     = mem_we_q;
      pix_count_d  = pix_count_q;
      drop_count_d = drop_count_q;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pix_d   = fifo_mem[rd_ptr_q];
               state_d = CALC;
            end
         end
         CALC: begin
            // Arithmetic done at ADDR_W bits gives the truncated address.
            mem_addr_d = ADDR_W'(pix_q.y) * ADDR_W'(H_RES) + ADDR_W'(pix_q.x);
            mem_data_d = pix_q.color;
`ifdef PIXEL_WRITER_CLIP_EN
            if (out_of_range) begin
               drop_count_d = drop_count_q + 16'd1;
               state_d      = IDLE;
            end else begin
               mem_we_d = 1'b1;
               state_d  = WRITE;
            end
`else
            mem_we_d = 1'b1;
            state_d  = WRITE;
`endif
         end
         WRITE: begin
            // Address and data stay registered until memory accepts.
            if (bus.mem_ack) begin
               mem_we_d    = 1'b0;
               pix_count_d = pix_count_q + 20'd1;
               state_d     = IDLE;
            end
         end
         default: begin
            mem_we_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state_q      <= IDLE;
         pix_q        <= '0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_we_q     <= 1'b0;
         pix_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         pix_q        <= pix_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_we_q     <= mem_we_d;
         pix_count_q  <= pix_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_data   = mem_data_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.pix_count  = pix_count_q;
   assign bus.drop_count = drop_count_q;
   assign bus.busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer -- directed self-checking bench for pixel_writer.
// Expected writes are computed by the bench (y*640 + x, Bresenham line points)
// and compared against writes observed on the memory port in order.
module tb_pixel_writer;

   localparam int ADDR_W  = 19;
   localparam int COLOR_W = 12;
   localparam int H_RES   = 640;

   logic clk = 1'b0;
   logic rst_;
   logic ack_fixed;
   logic ack_rand_en;
   logic ack_rand = 1'b0;

   int checks    = 0;
   int errors    = 0;
   int we_cycles = 0;
   int got_idx   = 0;
   int we_base;
   int got_base;
   int n;

   // Line generator working variables
   int lx, ly, lx1, ly1, ldx, ldy, lsx, lsy, lerr, le2, npix;

   logic [ADDR_W-1:0]  got_addr [$];
   logic [COLOR_W-1:0] got_data [$];
   logic [ADDR_W-1:0]  exp_addr [$];
   logic [COLOR_W-1:0] exp_data [$];

   pixel_writer_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

   pixel_writer #(
      .H_RES(640), .V_RES(480), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(4)
   ) dut (
      .clk (clk),
      .rst_(rst_),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_ack = ack_rand_en ? ack_rand : ack_fixed;

   always @(negedge clk) ack_rand = 1'($urandom_range(0, 1));

   // Memory-side monitor: record every accepted write and count request cycles
   always @(posedge clk) begin
      if (!rst_ && bus.mem_we) begin
         we_cycles++;
         if (bus.mem_ack) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one pixel and hold in_rts until it is accepted
   task automatic push(input int x, input int y, input int c);
      int k = 0;
      @(negedge clk);
      bus.x_in     = 10'(x);
      bus.y_in     = 10'(y);
      bus.color_in = COLOR_W'(c);
      bus.in_rts   = 1'b1;
      while (!bus.in_rtr && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) begin
         check("push_timeout", 32'(k), 32'(0));
      end
      @(posedge clk);
      #1;
      bus.in_rts = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (bus.busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("drain_timeout", 32'(k < 2000), 32'(1));
   endtask

   task automatic expect_write(input int addr, input int data);
      exp_addr.push_back(ADDR_W'(addr));
      exp_data.push_back(COLOR_W'(data));
   endtask

   // Compare recorded writes against the expected list, in order
   task automatic check_writes(input string tag);
      check({tag, "_write_count"}, 32'(got_addr.size() - got_idx), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (got_idx + i < got_addr.size()) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[got_idx + i]), 32'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(got_data[got_idx + i]), 32'(exp_data[i]));
         end
      end
      got_idx = got_addr.size();
      exp_addr.delete();
      exp_data.delete();
   endtask

   initial begin
      rst_         = 1'b1;
      bus.in_rts   = 1'b0;
      bus.x_in     = '0;
      bus.y_in     = '0;
      bus.color_in = '0;
      ack_fixed    = 1'b1;
      ack_rand_en  = 1'b0;

      // ---------------- Reset values ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_rtr",     bus.in_rtr,     0);
      check("rst_mem_we",     bus.mem_we,     0);
      check("rst_mem_addr",   bus.mem_addr,   0);
      check("rst_mem_data",   bus.mem_data,   0);
      check("rst_busy",       bus.busy,       0);
      check("rst_pix_count",  bus.pix_count,  0);
      check("rst_drop_count", bus.drop_count, 0);
      rst_ = 1'b0;
      #1;
      check("post_rst_in_rtr", bus.in_rtr, 1);

      // ---------------- Single pixel latency ----------------
      push(4, 0, 12'hF00);                       // accepted at edge 0
      check("t1_busy_after_accept", bus.busy,   1);
      check("t1_we_edge0",          bus.mem_we, 0);
      @(posedge clk); #1;                        // edge 1: popped
      check("t1_we_edge1",          bus.mem_we, 0);
      @(posedge clk); #1;                        // edge 2: write requested
      check("t1_we_edge2",          bus.mem_we,   1);
      check("t1_addr",              bus.mem_addr, 4);
      check("t1_data",              bus.mem_data, 12'hF00);
      @(posedge clk); #1;                        // edge 3: acked
      check("t1_we_edge3",          bus.mem_we,    0);
      check("t1_pix_count",         bus.pix_count, 1);
      check("t1_busy_done",         bus.busy,      0);
      expect_write(4, 12'hF00);
      check_writes("t1");

      // ---------------- Address corners, one write per 3 cycles ----------------
      we_base = we_cycles;
      push(639, 479, 12'hABC);
      push(0, 10, 12'h123);
      wait_idle();
      expect_write(307199, 12'hABC);
      expect_write(6400,   12'h123);
      check_writes("t2");
      check("t2_pix_count", bus.pix_count, 3);
      check("t2_we_cycles", 32'(we_cycles - we_base), 2);

      // ---------------- Stall with mem_ack low ----------------
      ack_fixed = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(i, 1, 12'h010 + i);
         expect_write(H_RES + i, 12'h010 + i);
      end
      check("t3_rtr_full", bus.in_rtr, 0);
      repeat (4) @(negedge clk);
      check("t3_we_stalled",   bus.mem_we,    1);
      check("t3_addr_stalled", bus.mem_addr,  H_RES);
      check("t3_pix_stalled",  bus.pix_count, 3);
      @(negedge clk);
      bus.x_in     = 10'd5;
      bus.y_in     = 10'd1;
      bus.color_in = 12'h015;
      bus.in_rts   = 1'b1;
      repeat (3) @(negedge clk);
      check("t3_rtr_held_low", bus.in_rtr, 0);
      ack_fixed = 1'b1;
      push(5, 1, 12'h015);
      expect_write(H_RES + 5, 12'h015);
      wait_idle();
      check_writes("t3");
      check("t3_pix_count", bus.pix_count, 9);

      // ---------------- Clipping boundary ----------------
      push(640, 0, 12'h0F0);
      push(1, 1, 12'h00F);
      wait_idle();
`ifdef PIXEL_WRITER_CLIP_EN
      expect_write(641, 12'h00F);
      check_writes("t4");
      check("t4_drop_count", bus.drop_count, 1);
      check("t4_pix_count",  bus.pix_count,  10);
`else
      expect_write(640, 12'h0F0);
      expect_write(641, 12'h00F);
      check_writes("t4");
      check("t4_drop_count", bus.drop_count, 0);
      check("t4_pix_count",  bus.pix_count,  11);
`endif

      // ---------------- Reset during WRITE ----------------
      ack_fixed = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(2 + i, 2, 12'h100 + i);
      end
      n = 0;
      while (!bus.mem_we && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t5_we_before_rst", bus.mem_we, 1);
      @(negedge clk);
      we_base  = we_cycles;
      got_base = got_addr.size();
      rst_     = 1'b1;
      #1;
      check("t5_we_async_fall", bus.mem_we,     0);
      check("t5_pix_cleared",   bus.pix_count,  0);
      check("t5_drop_cleared",  bus.drop_count, 0);
      check("t5_busy_cleared",  bus.busy,       0);
      check("t5_rtr_in_rst",    bus.in_rtr,     0);
      @(negedge clk);
      rst_      = 1'b0;
      ack_fixed = 1'b1;
      #1;
      check("t5_rtr_after_rst", bus.in_rtr, 1);
      repeat (10) @(negedge clk);
      check("t5_no_we_after",    32'(we_cycles - we_base), 0);
      check("t5_no_writes",      32'(got_addr.size() - got_base), 0);
      check("t5_pix_still_zero", bus.pix_count, 0);
      got_idx = got_addr.size();

      // ---------------- Line (4,0)->(0,10) with random mem_ack ----------------
      ack_rand_en = 1'b1;
      lx   = 4;  ly  = 0;
      lx1  = 0;  ly1 = 10;
      ldx  = (lx1 > lx) ? (lx1 - lx) : (lx - lx1);
      lsx  = (lx < lx1) ? 1 : -1;
      ldy  = -((ly1 > ly) ? (ly1 - ly) : (ly - ly1));
      lsy  = (ly < ly1) ? 1 : -1;
      lerr = ldx + ldy;
      npix = 0;
      while (npix < 64) begin
         push(lx, ly, npix);
         expect_write(ly * H_RES + lx, npix);
         npix++;
         if (lx == lx1 && ly == ly1) break;
         le2 = 2 * lerr;
         if (le2 >= ldy) begin
            lerr = lerr + ldy;
            lx   = lx + lsx;
         end
         if (le2 <= ldx) begin
            lerr = lerr + ldx;
            ly   = ly + lsy;
         end
      end
      wait_idle();
      ack_rand_en = 1'b0;
      check_writes("t6");
      check("t6_pix_count", bus.pix_count, 32'(npix));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
